// File: rtl/coinc_window_channel.sv
// One detector channel: two-flop synchroniser, registered rising-edge detect
// and a retriggerable down-counter that holds the coincidence window open.
module coinc_window_channel #(
  parameter int WIN_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pulse_in,
  input  logic [WIN_W-1:0] window_len,
  output logic             edge_det,
  output logic             win_active
);

  localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
  localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};

  logic             sync1_q;
  logic             sync2_q;
  logic             sync3_q;
  logic             edge_q;
  logic             edge_d;
  logic [WIN_W-1:0] win_cnt_q;
  logic [WIN_W-1:0] win_cnt_d;

  // Rising edge of the synchronised level; registered so a click shows up three cycles after the pin.
  always_comb begin
    edge_d = sync2_q & ~sync3_q;
  end

  // Window (re)loads on every edge with a minimum length of one cycle, then runs down to zero.
  always_comb begin
    win_cnt_d = win_cnt_q;
    if (edge_q) begin
      win_cnt_d = (window_len == WIN_ZERO) ? WIN_ONE : window_len;
    end else if (win_cnt_q != WIN_ZERO) begin
      win_cnt_d = win_cnt_q - WIN_ONE;
    end else begin
      win_cnt_d = win_cnt_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      edge_q    <= 1'b0;
      win_cnt_q <= WIN_ZERO;
    end else begin
      sync1_q   <= pulse_in;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      edge_q    <= edge_d;
      win_cnt_q <= win_cnt_d;
    end
  end

  assign edge_det   = edge_q;
  assign win_active = (win_cnt_q != WIN_ZERO);

endmodule

// File: rtl/coincidence_window_counter.sv
// N-channel singles and masked-coincidence counter over a programmable gate,
// with saturating counters and a one-cycle result strobe.
module coincidence_window_counter #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 32,
  parameter int WIN_W  = 8,
  parameter int GATE_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_CH-1:0]       pulse_in,
  input  logic                  enable,
  input  logic [WIN_W-1:0]      window_len,
  input  logic [GATE_W-1:0]     gate_len,
  input  logic [N_CH-1:0]       coinc_mask,
  output logic [N_CH*CNT_W-1:0] singles_out,
  output logic [CNT_W-1:0]      coinc_out,
  output logic                  result_valid,
  output logic                  counting,
  output logic                  overflow
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_COUNT = 2'd1, ST_LATCH = 2'd2} state_t;

  localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]      CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [N_CH*CNT_W-1:0] SACC_ZERO = {(N_CH*CNT_W){1'b0}};
  localparam logic [GATE_W-1:0]     GATE_ZERO = {GATE_W{1'b0}};
  localparam logic [GATE_W-1:0]     GATE_ONE  = {{(GATE_W-1){1'b0}}, 1'b1};
  localparam logic [GATE_W-1:0]     GATE_TWO  = {{(GATE_W-2){1'b0}}, 2'b10};
  localparam logic [N_CH-1:0]       MASK_ZERO = {N_CH{1'b0}};

  // Saturating increment; the top bit flags an increment lost to saturation.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] value, input logic inc);
    logic [CNT_W:0] res;
    if (!inc) begin
      res = {1'b0, value};
    end else if (value == CNT_MAX) begin
      res = {1'b1, value};
    end else begin
      res = {1'b0, value + CNT_ONE};
    end
    return res;
  endfunction

  state_t                  state_q, state_d;
  logic [GATE_W-1:0]       gate_cnt_q, gate_cnt_d;
  logic [N_CH-1:0]         mask_q, mask_d;
  logic [N_CH*CNT_W-1:0]   sacc_q, sacc_d;
  logic [CNT_W-1:0]        cacc_q, cacc_d;
  logic                    gate_ovf_q, gate_ovf_d;
  logic [N_CH*CNT_W-1:0]   singles_q, singles_d;
  logic [CNT_W-1:0]        coinc_q, coinc_d;
  logic                    overflow_q, overflow_d;
  logic                    valid_q, valid_d;
  logic                    counting_q, counting_d;
  logic                    all_in_q;

  logic [N_CH-1:0]         edge_vec_s;
  logic [N_CH-1:0]         win_vec_s;
  logic                    all_in_s;
  logic                    coinc_evt_s;
  logic [N_CH*CNT_W-1:0]   ssum_s;
  logic [N_CH-1:0]         sovf_s;
  logic [CNT_W-1:0]        csum_s;
  logic                    covf_s;
  logic                    evt_ovf_s;
  logic [GATE_W-1:0]       gate_load_s;
  state_t                  first_state_s;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    coinc_window_channel #(.WIN_W(WIN_W)) u_ch (
      .clock      (clock),
      .reset      (reset),
      .pulse_in   (pulse_in[k]),
      .window_len (window_len),
      .edge_det   (edge_vec_s[k]),
      .win_active (win_vec_s[k])
    );
  end

  // Coincidence condition and its rising edge; an empty mask never coincides.
  always_comb begin
    all_in_s    = (mask_q != MASK_ZERO) && ((win_vec_s & mask_q) == mask_q);
    coinc_evt_s = all_in_s & ~all_in_q;
  end

  // Accumulator values including this cycle's events, plus saturation flags.
  always_comb begin
    ssum_s = SACC_ZERO;
    sovf_s = MASK_ZERO;
    for (int k = 0; k < N_CH; k++) begin
      {sovf_s[k], ssum_s[k*CNT_W +: CNT_W]} = sat_inc(sacc_q[k*CNT_W +: CNT_W], edge_vec_s[k]);
    end
    {covf_s, csum_s} = sat_inc(cacc_q, coinc_evt_s);
    evt_ovf_s        = (|sovf_s) | covf_s;
  end

  // Gate start configuration; a zero gate length behaves as one cycle.
  always_comb begin
    gate_load_s   = (gate_len == GATE_ZERO) ? GATE_ONE : gate_len;
    first_state_s = (gate_load_s == GATE_ONE) ? ST_LATCH : ST_COUNT;
  end

  // Gate FSM: the LATCH cycle is the last cycle of the gate, so a restart has no dead time.
  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    mask_d     = mask_q;
    sacc_d     = sacc_q;
    cacc_d     = cacc_q;
    gate_ovf_d = gate_ovf_q;
    singles_d  = singles_q;
    coinc_d    = coinc_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sacc_d     = SACC_ZERO;
        cacc_d     = CNT_ZERO;
        gate_ovf_d = 1'b0;
        if (enable) begin
          state_d    = first_state_s;
          gate_cnt_d = gate_load_s;
          mask_d     = coinc_mask;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (!enable) begin
          state_d    = ST_IDLE;
          sacc_d     = SACC_ZERO;
          cacc_d     = CNT_ZERO;
          gate_ovf_d = 1'b0;
        end else begin
          sacc_d     = ssum_s;
          cacc_d     = csum_s;
          gate_ovf_d = gate_ovf_q | evt_ovf_s;
          gate_cnt_d = gate_cnt_q - GATE_ONE;
          if (gate_cnt_q == GATE_TWO) begin
            state_d = ST_LATCH;
          end else begin
            state_d = ST_COUNT;
          end
        end
      end
      ST_LATCH: begin
        singles_d  = ssum_s;
        coinc_d    = csum_s;
        overflow_d = gate_ovf_q | evt_ovf_s;
        valid_d    = 1'b1;
        sacc_d     = SACC_ZERO;
        cacc_d     = CNT_ZERO;
        gate_ovf_d = 1'b0;
        if (enable) begin
          state_d    = first_state_s;
          gate_cnt_d = gate_load_s;
          mask_d     = coinc_mask;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        sacc_d     = SACC_ZERO;
        cacc_d     = CNT_ZERO;
        gate_ovf_d = 1'b0;
      end
    endcase
    counting_d = (state_d == ST_COUNT) || (state_d == ST_LATCH);
  end

  // State, accumulator and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gate_cnt_q <= GATE_ZERO;
      mask_q     <= MASK_ZERO;
      sacc_q     <= SACC_ZERO;
      cacc_q     <= CNT_ZERO;
      gate_ovf_q <= 1'b0;
      singles_q  <= SACC_ZERO;
      coinc_q    <= CNT_ZERO;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      counting_q <= 1'b0;
      all_in_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      mask_q     <= mask_d;
      sacc_q     <= sacc_d;
      cacc_q     <= cacc_d;
      gate_ovf_q <= gate_ovf_d;
      singles_q  <= singles_d;
      coinc_q    <= coinc_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      counting_q <= counting_d;
      all_in_q   <= all_in_s;
    end
  end

  assign singles_out  = singles_q;
  assign coinc_out    = coinc_q;
  assign result_valid = valid_q;
  assign counting     = counting_q;
  assign overflow     = overflow_q;

endmodule

// File: doc/coincidence_window_counter.md
Name: coincidence_window_counter

Overview:
N-channel coincidence counter, the parametrised successor to the bare two-input AND coincidence.
- Each detector click is synchronised and edge-detected, then stretched into a programmable coincidence window.
- Singles per channel and coincidences across a programmable channel mask are counted over a programmable gate time.
- Results are latched with a one-cycle valid strobe for the readout logic. Sits between the detector input pins and the readout/UART path, clocked from the clock-wizard output.

Parameters:
N_CH, 4, number of detector channels (2..8)
CNT_W, 32, width of each singles/coincidence counter
WIN_W, 8, width of window_len
GATE_W, 32, width of gate_len

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
pulse_in  in  N_CH  asynchronous detector clicks, one bit per channel
enable  in  1  level; 1 = run gates back-to-back, 0 = stop
window_len  in  WIN_W  coincidence window length in clock cycles
gate_len  in  GATE_W  gate length in clock cycles
coinc_mask  in  N_CH  channels that must all be in-window for a coincidence
singles_out  out  N_CH*CNT_W  latched singles counts; channel k at [k*CNT_W +: CNT_W]
coinc_out  out  CNT_W  latched coincidence count
result_valid  out  1  one-cycle strobe when outputs update
counting  out  1  high while a gate is open
overflow  out  1  latched; some counter saturated in the reported gate

Behaviour:
Reset
- Every register and every output clears to 0.
- The FSM enters IDLE.

Per channel
- 2-flop synchroniser, then a rising-edge detect register. A click reaches edge_det 3 cycles after the pin rises.
- On edge_det, the window down-counter loads max(window_len,1). Otherwise it decrements while nonzero.
- win_active = (counter != 0).
- Edge during an active window: reload (retrigger). The singles count still increments.
- window_len is used live, at load time only.

Coincidence
- all_in = AND over channels with coinc_mask=1 of win_active.
- One event is counted per 0->1 transition of all_in, registered.
- coinc_mask = 0: all_in forced 0, no coincidences.
- Single-bit mask: coincidences equal that channel's non-overlapping windows.

FSM states: IDLE, COUNT, LATCH.
- IDLE
  - Accumulators are held at 0.
  - enable=1 -> COUNT. On entry: sample gate_len (0 treated as 1) and coinc_mask, load the gate counter, clear the accumulators.
- COUNT
  - counting=1. Accumulators increment on events. The gate counter decrements each cycle.
  - When the gate counter == 1 -> LATCH. The gate lasts exactly gate_len cycles.
  - enable=0 -> IDLE. Gate aborted, no result_valid, outputs keep their previous values.
- LATCH (1 cycle)
  - Copy the accumulators plus the events of this cycle into the output registers. Copy the overflow flag.
  - result_valid=1.
  - enable=1: restart COUNT with freshly cleared accumulators and re-sampled config. There is no dead time; events in the following cycle belong to the next gate.
  - enable=0: go to IDLE.

Arithmetic
- Counters saturate at all-ones and never wrap.
- Saturation sets a per-gate sticky flag that is cleared at gate start.
- Simultaneous edges on several channels each count once.

Reset mid-gate: immediate return to IDLE, everything cleared, no result_valid.

Decomposition:
- No shared package. Widths are module parameters.
- Field offsets are derived from CNT_W inside the module.
- Sub-module coinc_window_channel, one instance per channel. Contains the synchroniser, edge detect and window counter. Parameter WIN_W. Ports clock, reset, pulse_in, window_len, edge_det, win_active.

Test Plan:
1. N_CH=4, window_len=4, gate_len=100, mask=0011, enable=1. Ch0 and ch1 pulse at the same cycle, 5 times, 20 cycles apart -> singles ch0=ch1=5, ch2=ch3=0, coinc_out=5. result_valid exactly 100 cycles after the gate opens.
2. Ch1 pulse 3 cycles after ch0, window_len=4 -> coinc=1. With 5 cycles offset -> coinc=0. With window_len=0 and identical timing -> coinc=1, the 1-cycle minimum window overlapping.
3. Ch0 pulses every 2 cycles, window_len=8 -> one window retriggered. singles=N, coinc of mask=0001 is 1.
4. enable held high, gate_len=10, continuous ch2 pulse train at 1 per 2 cycles -> result_valid every 10 cycles. Consecutive singles_out[2] sum equals the total pulses, with no lost edge at the gate boundaries.
5. CNT_W=4, 20 pulses in one gate -> singles=15, overflow=1. Next gate with 3 pulses -> 3, overflow=0.
6. enable dropped mid-gate, and separately reset asserted mid-gate -> no result_valid. Abort: outputs keep their previous values. Reset: outputs are 0 and the FSM is in IDLE the next cycle.
